// File: rtl/action_decoder.sv
// Loopback decoder for the two-digit action display: debounces the active-low
// gfedcba segment pair and recovers the action code, flagging unknown pairs.
module action_decoder #(
  parameter logic [2:0]  dn            = 3'b000,
  parameter logic [2:0]  A1            = 3'b001,
  parameter logic [2:0]  up            = 3'b010,
  parameter logic [2:0]  A2            = 3'b011,
  parameter logic [2:0]  r1            = 3'b100,
  parameter logic [2:0]  r2            = 3'b101,
  parameter logic [2:0]  nothing       = 3'b110,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg1_in,
  input  logic [6:0] seg2_in,
  output logic [2:0] action,
  output logic       action_valid,
  output logic       action_strobe,
  output logic       err,
  output logic [7:0] err_cnt
);

  localparam int unsigned PAIR_W = 14;
  localparam int unsigned CNT_W  = 8;
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_ACC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ERR_MAX  = '1;
  localparam logic [PAIR_W-1:0] P_BLANK  = '1;
  localparam logic [PAIR_W-1:0] P_DN     = {7'b0100001, 7'b0101011};
  localparam logic [PAIR_W-1:0] P_A1     = {7'b0001000, 7'b1111001};
  localparam logic [PAIR_W-1:0] P_UP     = {7'b1000001, 7'b0001100};
  localparam logic [PAIR_W-1:0] P_A2     = {7'b0001000, 7'b0100100};
  localparam logic [PAIR_W-1:0] P_R1     = {7'b0101111, 7'b1111001};
  localparam logic [PAIR_W-1:0] P_R2     = {7'b0101111, 7'b0100100};

  typedef enum logic [1:0] {S_EMPTY, S_VALID, S_BAD} state_t;

  state_t             r_state, w_state_nxt;
  logic [PAIR_W-1:0]  r_samp;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_fired;
  logic [2:0]         r_action, w_action_nxt;
  logic               r_strobe, w_strobe_nxt;
  logic               r_valid, r_err;
  logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
  logic [PAIR_W-1:0]  w_pair;
  logic               w_same, w_accept, w_hit;
  logic [2:0]         w_code;

  assign w_pair   = {seg1_in, seg2_in};
  assign w_same   = (w_pair == r_samp);
  assign w_accept = w_same && !r_fired && (r_cnt == CNT_ACC);

  // Both digits must match: single digits are shared between table entries.
  always_comb begin : pair_decode
    w_hit  = 1'b1;
    w_code = nothing;
    case (w_pair)
      P_DN:    w_code = dn;
      P_A1:    w_code = A1;
      P_UP:    w_code = up;
      P_A2:    w_code = A2;
      P_R1:    w_code = r1;
      P_R2:    w_code = r2;
      P_BLANK: w_code = nothing;
      default: w_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : stability
    if (!rst_n) begin
      r_samp  <= P_BLANK;
      r_cnt   <= '0;
      r_fired <= 1'b0;
    end else begin
      r_samp <= w_pair;
      if (!w_same) begin
        r_cnt   <= '0;
        r_fired <= 1'b0;
      end else begin
        if (r_cnt < CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
        if (w_accept) r_fired <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : state_reg
    if (!rst_n) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  always_comb begin : fsm_next
    w_state_nxt   = r_state;
    w_action_nxt  = r_action;
    w_strobe_nxt  = 1'b0;
    w_err_cnt_nxt = r_err_cnt;
    if (w_accept) begin
      if (w_hit) begin
        w_state_nxt  = S_VALID;
        w_action_nxt = w_code;
        w_strobe_nxt = (r_state != S_VALID) || (w_code != r_action);
      end else begin
        w_state_nxt  = S_BAD;
        w_strobe_nxt = (r_state == S_VALID);
        if (r_err_cnt != ERR_MAX) w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : out_regs
    if (!rst_n) begin
      r_action  <= nothing;
      r_strobe  <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_action  <= w_action_nxt;
      r_strobe  <= w_strobe_nxt;
      r_valid   <= (w_state_nxt == S_VALID);
      r_err     <= (w_state_nxt == S_BAD);
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign action        = r_action;
  assign action_valid  = r_valid;
  assign action_strobe = r_strobe;
  assign err           = r_err;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_action_decoder.sv
// Bench for action_decoder: two instances (STABLE_CYCLES 4 and 1) on shared
// inputs, checked every cycle against a run-length reference model.
module tb_action_decoder;

  localparam logic [13:0] P_BLANK = 14'h3FFF;
  localparam logic [13:0] P_DN    = {7'b0100001, 7'b0101011};
  localparam logic [13:0] P_A1    = {7'b0001000, 7'b1111001};
  localparam logic [13:0] P_UP    = {7'b1000001, 7'b0001100};
  localparam logic [13:0] P_A2    = {7'b0001000, 7'b0100100};
  localparam logic [13:0] P_R1    = {7'b0101111, 7'b1111001};
  localparam logic [13:0] P_R2    = {7'b0101111, 7'b0100100};
  localparam logic [13:0] P_BADA  = {7'b0001000, 7'b0101011};
  localparam logic [13:0] P_BADB  = {7'b0101111, 7'b0101011};

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg1, seg2;
  logic [2:0] a4, a1;
  logic       v4, v1, s4, s1, e4, e1;
  logic [7:0] c4, c1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  logic [13:0] tbl_pair [7];
  logic [2:0]  tbl_code [7];

  logic [13:0] m_last [2];
  int          m_run  [2];
  logic [2:0]  m_act  [2];
  logic        m_val  [2];
  logic        m_err  [2];
  logic        m_stb  [2];
  int          m_ecnt [2];

  always #5 clk = ~clk;

  action_decoder #(.STABLE_CYCLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .seg1_in(seg1), .seg2_in(seg2),
    .action(a4), .action_valid(v4), .action_strobe(s4), .err(e4), .err_cnt(c4));

  action_decoder #(.STABLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .seg1_in(seg1), .seg2_in(seg2),
    .action(a1), .action_valid(v1), .action_strobe(s1), .err(e1), .err_cnt(c1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sc_of(input int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic model_reset(input int i);
    m_last[i] = P_BLANK;
    m_run[i]  = 1;
    m_act[i]  = 3'b110;
    m_val[i]  = 1'b0;
    m_err[i]  = 1'b0;
    m_stb[i]  = 1'b0;
    m_ecnt[i] = 0;
  endtask

  // A pair is accepted at the edge where it has been seen for STABLE_CYCLES+1
  // consecutive samples (reset counts as one blank sample).
  task automatic model_edge(input int i, input logic [13:0] p);
    logic [2:0] old_act;
    logic       old_val, hit;
    logic [2:0] code;
    if (p == m_last[i]) m_run[i] = m_run[i] + 1;
    else                m_run[i] = 1;
    m_last[i] = p;
    m_stb[i]  = 1'b0;
    if (m_run[i] == sc_of(i) + 1) begin
      old_act = m_act[i];
      old_val = m_val[i];
      hit  = 1'b0;
      code = 3'b000;
      for (int k = 0; k < 7; k++)
        if (tbl_pair[k] == p) begin hit = 1'b1; code = tbl_code[k]; end
      if (hit) begin
        m_act[i] = code;
        m_val[i] = 1'b1;
        m_err[i] = 1'b0;
      end else begin
        m_val[i] = 1'b0;
        m_err[i] = 1'b1;
        if (m_ecnt[i] < 255) m_ecnt[i] = m_ecnt[i] + 1;
      end
      m_stb[i] = (m_act[i] != old_act) || (m_val[i] != old_val);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) model_reset(i);
      else        model_edge(i, {seg1, seg2});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m4_action", 32'(a4), 32'(m_act[0]));
      check("m4_valid",  32'(v4), 32'(m_val[0]));
      check("m4_strobe", 32'(s4), 32'(m_stb[0]));
      check("m4_err",    32'(e4), 32'(m_err[0]));
      check("m4_errcnt", 32'(c4), 32'(m_ecnt[0]));
      check("m1_action", 32'(a1), 32'(m_act[1]));
      check("m1_valid",  32'(v1), 32'(m_val[1]));
      check("m1_strobe", 32'(s1), 32'(m_stb[1]));
      check("m1_err",    32'(e1), 32'(m_err[1]));
      check("m1_errcnt", 32'(c1), 32'(m_ecnt[1]));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [13:0] p);
    {seg1, seg2} = p;
  endtask

  initial begin
    logic [31:0] rnd;
    logic [13:0] p;
    int          sel;

    tbl_pair[0] = P_DN;    tbl_code[0] = 3'b000;
    tbl_pair[1] = P_A1;    tbl_code[1] = 3'b001;
    tbl_pair[2] = P_UP;    tbl_code[2] = 3'b010;
    tbl_pair[3] = P_A2;    tbl_code[3] = 3'b011;
    tbl_pair[4] = P_R1;    tbl_code[4] = 3'b100;
    tbl_pair[5] = P_R2;    tbl_code[5] = 3'b101;
    tbl_pair[6] = P_BLANK; tbl_code[6] = 3'b110;

    rst_n = 1'b0;
    drive(P_BLANK);
    tick(2);
    chk_en = 1'b1;
    rst_n  = 1'b1;
    check("rst_action", 32'(a4), 32'd6);
    check("rst_valid",  32'(v4), 32'd0);
    check("rst_errcnt", 32'(c4), 32'd0);

    // Blank accepted at the fourth edge after release.
    tick(3);
    check("blank_pre_valid", 32'(v4), 32'd0);
    tick(1);
    check("blank_action", 32'(a4), 32'd6);
    check("blank_valid",  32'(v4), 32'd1);
    check("blank_strobe", 32'(s4), 32'd1);
    check("blank_err",    32'(e4), 32'd0);
    tick(1);
    check("blank_strobe_end", 32'(s4), 32'd0);

    drive(P_A1);
    tick(4);
    check("a1_pre_action", 32'(a4), 32'd6);
    tick(1);
    check("a1_action", 32'(a4), 32'd1);
    check("a1_strobe", 32'(s4), 32'd1);
    tick(1);
    check("a1_strobe_end", 32'(s4), 32'd0);

    drive(P_A2);
    tick(4);
    check("a2_pre_action", 32'(a4), 32'd1);
    tick(1);
    check("a2_action", 32'(a4), 32'd3);
    check("a2_strobe", 32'(s4), 32'd1);

    // Short glitch to up, then back to A2: re-accept without strobe.
    drive(P_UP);
    tick(2);
    drive(P_A2);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("glitch_strobe", 32'(s4), 32'd0);
      check("glitch_action", 32'(a4), 32'd3);
    end

    drive(P_BADA);
    tick(4);
    check("bad_pre_err", 32'(e4), 32'd0);
    tick(1);
    check("bad_err",    32'(e4), 32'd1);
    check("bad_valid",  32'(v4), 32'd0);
    check("bad_errcnt", 32'(c4), 32'd1);
    check("bad_action", 32'(a4), 32'd3);
    check("bad_strobe", 32'(s4), 32'd1);

    drive(P_DN);
    tick(5);
    check("dn_action", 32'(a4), 32'd0);
    check("dn_valid",  32'(v4), 32'd1);
    check("dn_err",    32'(e4), 32'd0);
    check("dn_errcnt", 32'(c4), 32'd1);
    check("dn_strobe", 32'(s4), 32'd1);

    // Reset while cnt is 2 on a new pattern.
    drive(P_R1);
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_action", 32'(a4), 32'd6);
    check("mid_rst_valid",  32'(v4), 32'd0);
    check("mid_rst_errcnt", 32'(c4), 32'd0);
    check("mid_rst_err",    32'(e4), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    check("post_rst_pre_action", 32'(a4), 32'd6);
    check("post_rst_pre_valid",  32'(v4), 32'd0);
    tick(1);
    check("post_rst_action", 32'(a4), 32'd4);
    check("post_rst_strobe", 32'(s4), 32'd1);

    // STABLE_CYCLES=1 instance: 300 invalid accepts saturate at 255.
    for (int k = 0; k < 300; k++) begin
      drive((k % 2 == 0) ? P_BADA : P_BADB);
      tick(2);
    end
    check("sat_errcnt", 32'(c1), 32'd255);
    check("sat_err",    32'(e1), 32'd1);

    for (int k = 0; k < 400; k++) begin
      sel = int'($urandom_range(0, 9));
      rnd = $urandom;
      if (sel < 7)       p = tbl_pair[sel];
      else if (sel == 7) p = P_BADA;
      else if (sel == 8) p = P_BADB;
      else               p = rnd[13:0];
      drive(p);
      if ($urandom_range(0, 49) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick(int'($urandom_range(1, 6)));
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
